fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction fetch stage directly upstream of `IMEM`. Owns the program counter, issues word fetches to `IMEM` over the `instrfetch`/`addr_imem` → `instr`/`instr_fetched` interface, and buffers the returned words with their PCs. It hands `{pc, instr}` pairs to the decoder through a valid/ready handshake. It accepts branch/jump redirects from execute and flags fetches outside instruction memory.

## Interface
- `RESET_PC`, 32'h0100_0000, PC loaded on reset; base of instruction memory.
- `IMEM_BASE`, 20'h01000, required value of `addr[31:12]` for a legal fetch.
- `IMEM_BYTES`, 2048, populated IMEM size in bytes; legal offsets are 0..IMEM_BYTES-4.
- `FIFO_DEPTH`, 2, entries in the output buffer; must be ≥2.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `instrfetch` out 1: fetch request to IMEM for this cycle.
- `addr_imem` out 32: byte address of the request; equals the current PC.
- `instr` in 32: IMEM read data, valid when `instr_fetched`=1.
- `instr_fetched` in 1: IMEM response strobe, one cycle after an accepted request.
- `redirect_valid` in 1: execute requests a PC change.
- `redirect_pc` in 32: new PC.
- `dec_valid` out 1: buffer head is valid.
- `dec_instr` out 32: instruction at the buffer head.
- `dec_pc` out 32: PC of `dec_instr`.
- `dec_ready` in 1: decoder accepts the head on this cycle.
- `fetch_fault` out 1: sticky fetch fault.
- `fault_pc` out 32: PC that caused the fault.

## Operation
- Registered state:
  - `pc`
  - `inflight` (0/1): a request was issued last cycle.
  - `drop` (0/1): discard the in-flight response.
  - FIFO of `{pc, instr}`.
  - Fault flag and `fault_pc`.
- `pop` = `dec_valid & dec_ready`.
- Issue condition: `issue` = !`rst` & !fault & `pc_legal` & (count + `inflight` − `pop`) < FIFO_DEPTH.
  - `instrfetch` = `issue`.
  - `addr_imem` = `pc`, combinationally.
- On `issue`: `pc` ← `pc`+4; `inflight` ← 1, recording the request PC.
- In the cycle after an issue, `instr_fetched`=1 and !`drop` pushes `{req_pc, instr}`.
  - Push and pop may happen in the same cycle; count is unchanged.
- Redirect (`redirect_valid`=1), which overrides issue in that cycle:
  - FIFO flushed.
  - `pc` ← `redirect_pc`; fault cleared.
  - If a request is in flight, `drop` ← 1 so its response next cycle is discarded.
  - A `pop` in the same cycle still counts as consumed by the decoder.
- No wrap protection beyond the legality check: `pc`+4 is 32-bit modular.

## Timing
- Reset values:
  - `instrfetch`=0, `addr_imem`=RESET_PC.
  - `dec_valid`=0, `dec_instr`=0, `dec_pc`=0.
  - `fetch_fault`=0, `fault_pc`=0.
  - `inflight`=0, `drop`=0, FIFO empty.
- First request: in the first cycle after `rst` deasserts.
- Latency, issue (cycle N) → `dec_valid` with that word (cycle N+2): 2 cycles.
- Throughput: one instruction per cycle while `dec_ready`=1.
- `dec_valid`=1 with `dec_ready`=0: `dec_instr`/`dec_pc` hold stable.
- Redirect at cycle N: `addr_imem`=`redirect_pc` with `instrfetch`=1 at N+1, and `dec_valid`=0 at N+1.
- `rst` mid-operation: all state returns to reset values on the next edge; an in-flight response is ignored.

## Configuration
- `FETCH_RANGE_CHECK_EN` defined:
  - `pc_legal` = (`pc[1:0]`==0) & (`pc[31:12]`==IMEM_BASE) & (`pc[11:0]` < IMEM_BYTES).
  - An illegal PC is never issued. Once the FIFO drains and `inflight`=0, the unit sets `fetch_fault`=1 and `fault_pc`=`pc`.
  - A missing `instr_fetched` after an issue also sets the fault, with `fault_pc`=request PC.
  - The fault holds until a redirect or `rst`.
- Not defined:
  - `pc_legal` is tied 1.
  - `fetch_fault` and `fault_pc` are tied 0.
  - A missing response is simply not pushed.

## Structure
- `fetch_pkg` holds:
  - RESET_PC and IMEM_BASE constants.
  - The `fetch_entry_t` struct `{pc[31:0], instr[31:0]}`.
- Sub-module `fetch_fifo`: synchronous FIFO of `fetch_entry_t`, FIFO_DEPTH entries.
  - Ports: push, pop, flush, count, head.
  - Flush has priority over push.

## Test plan
- Reset, then `dec_ready`=1 → `addr_imem` 0x01000000, 0x01000004, … on consecutive cycles; first `dec_valid` 2 cycles after the first issue with `dec_pc`=0x01000000.
- Hold `dec_ready`=0 for 5 cycles → at most FIFO_DEPTH entries buffered, `instrfetch`=0 once full, head stable; release → in-order delivery, no loss or duplicate.
- `redirect_valid` with `redirect_pc`=0x01000100 while a request is in flight → stale response dropped; next `dec_pc`=0x01000100.
- Redirect and `pop` in the same cycle → popped entry delivered once; FIFO empty on the next cycle.
- With `FETCH_RANGE_CHECK_EN`, sequential fetch to 0x01000800 → no request at 0x01000800; `fetch_fault`=1 and `fault_pc`=0x01000800 after the last word drains; a redirect clears the fault.
- Force `instr_fetched`=0 after an issue → `fetch_fault`=1 with `fault_pc` equal to the request PC.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
// Range checking of fetch PCs is enabled with FETCH_RANGE_CHECK_EN.
package fetch_pkg;

   localparam logic [31:0] RESET_PC = 32'h0100_0000;
   localparam logic [19:0] IMEM_BASE = 20'h01000;
   localparam int unsigned DEF_IMEM_BYTES = 2048;
   localparam int unsigned DEF_FIFO_DEPTH = 2;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } fetch_entry_t;

   function automatic logic [31:0] pc_next(input logic [31:0] pc);
      return pc + 32'd4;
   endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO of {pc, instr} fetch entries.
// Flush has priority over push; pop on empty and push on full are ignored.
module fetch_fifo
   import fetch_pkg::*;
#(
   parameter int unsigned DEPTH = 2,
   localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   localparam int unsigned CW = $clog2(DEPTH + 1)
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         push_i,
   input  fetch_entry_t entry_i,
   input  logic         pop_i,
   input  logic         flush_i,
   output logic [CW-1:0] count_o,
   output fetch_entry_t head_o
);

   fetch_entry_t mem_q [DEPTH];
   logic [AW-1:0] wptr_q;
   logic [AW-1:0] rptr_q;
   logic [CW-1:0] cnt_q;
   logic pop_en;
   logic push_en;

   function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
      return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   assign pop_en  = pop_i & (cnt_q != '0);
   assign push_en = push_i & ((cnt_q != CW'(DEPTH)) | pop_en);

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < int'(DEPTH); i++) begin
            mem_q[i] <= '0;
         end
         wptr_q <= '0;
         rptr_q <= '0;
         cnt_q  <= '0;
      end else if (flush_i) begin
         wptr_q <= '0;
         rptr_q <= '0;
         cnt_q  <= '0;
      end else begin
         if (push_en) begin
            mem_q[wptr_q] <= entry_i;
            wptr_q <= ptr_inc(wptr_q);
         end
         if (pop_en) begin
            rptr_q <= ptr_inc(rptr_q);
         end
         unique case ({push_en, pop_en})
            2'b10:   cnt_q <= cnt_q + 1'b1;
            2'b01:   cnt_q <= cnt_q - 1'b1;
            default: cnt_q <= cnt_q;
         endcase
      end
   end

   assign count_o = cnt_q;
   assign head_o  = mem_q[rptr_q];

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, IMEM request/response, decoder buffer.
// Define FETCH_RANGE_CHECK_EN to enable PC range checking and fetch faults.
module fetch_unit #(
   parameter logic [31:0] RESET_PC   = fetch_pkg::RESET_PC,
   parameter logic [19:0] IMEM_BASE  = fetch_pkg::IMEM_BASE,
   parameter int unsigned IMEM_BYTES = fetch_pkg::DEF_IMEM_BYTES,
   parameter int unsigned FIFO_DEPTH = fetch_pkg::DEF_FIFO_DEPTH
) (
   input  logic        clk,
   input  logic        rst,
   output logic        instrfetch,
   output logic [31:0] addr_imem,
   input  logic [31:0] instr,
   input  logic        instr_fetched,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        dec_valid,
   output logic [31:0] dec_instr,
   output logic [31:0] dec_pc,
   input  logic        dec_ready,
   output logic        fetch_fault,
   output logic [31:0] fault_pc
);
   import fetch_pkg::*;

   localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);

   if (FIFO_DEPTH < 2) begin : g_depth_chk
      $error("fetch_unit: FIFO_DEPTH must be at least 2");
   end
   if (IMEM_BYTES > 4096 || IMEM_BYTES < 4) begin : g_size_chk
      $error("fetch_unit: IMEM_BYTES must fit one 4 KiB page");
   end
   if (RESET_PC[31:12] != IMEM_BASE) begin : g_base_chk
      $error("fetch_unit: RESET_PC must lie inside IMEM");
   end

   logic [31:0] pc_q, pc_d;
   logic [31:0] req_pc_q, req_pc_d;
   logic inflight_q, inflight_d;
   logic drop_q, drop_d;

   logic [CW-1:0] cnt;
   fetch_entry_t head;
   fetch_entry_t push_entry;
   logic pop;
   logic push;
   logic issue;
   logic pc_legal;
   logic fault_q;
   logic [31:0] occ;

   assign dec_valid = (cnt != '0);
   assign pop = dec_valid & dec_ready;
   // occupancy once the outstanding response lands and this pop retires
   assign occ = 32'(cnt) + 32'(inflight_q) - 32'(pop);

   assign issue = !rst & !fault_q & pc_legal & !redirect_valid
                & (occ < 32'(FIFO_DEPTH));
   assign push  = inflight_q & instr_fetched & !drop_q;

   assign instrfetch = issue;
   assign addr_imem  = pc_q;

   assign push_entry.pc    = req_pc_q;
   assign push_entry.instr = instr;

   assign dec_instr = dec_valid ? head.instr : '0;
   assign dec_pc    = dec_valid ? head.pc : '0;

   always_comb begin
      pc_d       = pc_q;
      req_pc_d   = req_pc_q;
      inflight_d = issue;
      drop_d     = redirect_valid & inflight_q;
      if (redirect_valid) begin
         pc_d = redirect_pc;
      end else if (issue) begin
         pc_d     = pc_next(pc_q);
         req_pc_d = pc_q;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pc_q       <= RESET_PC;
         req_pc_q   <= '0;
         inflight_q <= 1'b0;
         drop_q     <= 1'b0;
      end else begin
         pc_q       <= pc_d;
         req_pc_q   <= req_pc_d;
         inflight_q <= inflight_d;
         drop_q     <= drop_d;
      end
   end

   fetch_fifo #(
      .DEPTH(FIFO_DEPTH)
   ) u_fifo (
      .clk    (clk),
      .rst    (rst),
      .push_i (push),
      .entry_i(push_entry),
      .pop_i  (pop),
      .flush_i(redirect_valid),
      .count_o(cnt),
      .head_o (head)
   );

`ifdef FETCH_RANGE_CHECK_EN
   logic [31:0] fault_pc_q;
   logic miss;
   logic stall_illegal;

   assign pc_legal = (pc_q[1:0] == 2'b00)
                   & (pc_q[31:12] == IMEM_BASE)
                   & (32'(pc_q[11:0]) < IMEM_BYTES);

   assign miss = inflight_q & !instr_fetched & !drop_q;
   // an illegal PC faults only once every earlier word has been delivered
   assign stall_illegal = !pc_legal & (cnt == '0) & !inflight_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         fault_q    <= 1'b0;
         fault_pc_q <= '0;
      end else if (redirect_valid) begin
         fault_q    <= 1'b0;
         fault_pc_q <= '0;
      end else if (!fault_q) begin
         if (miss) begin
            fault_q    <= 1'b1;
            fault_pc_q <= req_pc_q;
         end else if (stall_illegal) begin
            fault_q    <= 1'b1;
            fault_pc_q <= pc_q;
         end
      end
   end

   assign fetch_fault = fault_q;
   assign fault_pc    = fault_pc_q;
`else
   assign pc_legal    = 1'b1;
   assign fault_q     = 1'b0;
   assign fetch_fault = 1'b0;
   assign fault_pc    = '0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed vector bench for fetch_unit with a one-cycle IMEM model.
module tb_fetch_unit;

   localparam logic [31:0] P   = 32'h0100_0000;
   localparam logic [31:0] KEY = 32'hDEAD_0000;
   localparam int NV = 25;

   logic        clk = 1'b0;
   logic        rst;
   logic        instrfetch;
   logic [31:0] addr_imem;
   logic [31:0] instr = '0;
   logic        instr_fetched = 1'b0;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        dec_valid;
   logic [31:0] dec_instr;
   logic [31:0] dec_pc;
   logic        dec_ready;
   logic        fetch_fault;
   logic [31:0] fault_pc;
   logic        miss = 1'b0;

   int nvec = 0;
   int nmis = 0;

   always #5 clk = ~clk;

   fetch_unit dut (
      .clk           (clk),
      .rst           (rst),
      .instrfetch    (instrfetch),
      .addr_imem     (addr_imem),
      .instr         (instr),
      .instr_fetched (instr_fetched),
      .redirect_valid(redirect_valid),
      .redirect_pc   (redirect_pc),
      .dec_valid     (dec_valid),
      .dec_instr     (dec_instr),
      .dec_pc        (dec_pc),
      .dec_ready     (dec_ready),
      .fetch_fault   (fetch_fault),
      .fault_pc      (fault_pc)
   );

   // IMEM: responds one cycle after each request unless told to miss
   always @(posedge clk) begin
      instr_fetched <= instrfetch && !miss;
      instr <= instrfetch ? (addr_imem ^ KEY) : 32'h0;
   end

   typedef struct {
      logic        rst;
      logic        rdy;
      logic        rv;
      logic [31:0] rpc;
      logic        fetch;
      logic [31:0] addr;
      logic        dv;
      logic [31:0] dpc;
   } vec_t;

   vec_t tbl [NV];

   function automatic vec_t mk(input logic r, input logic rd,
                               input logic rv, input logic [31:0] rpc,
                               input logic f, input logic [31:0] a,
                               input logic dv, input logic [31:0] dpc);
      vec_t v;
      v.rst = r; v.rdy = rd; v.rv = rv; v.rpc = rpc;
      v.fetch = f; v.addr = a; v.dv = dv; v.dpc = dpc;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      nvec++;
      if (act !== exp) begin
         nmis++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic step(input logic r, input logic rd,
                       input logic rv, input logic [31:0] rpc);
      @(negedge clk);
      rst = r;
      dec_ready = rd;
      redirect_valid = rv;
      redirect_pc = rpc;
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] got [$];
      logic saw800;
      logic found;

      tbl[0]  = mk(1, 1, 0, 0, 0, P,         0, 0);
      tbl[1]  = mk(0, 1, 0, 0, 1, P,         0, 0);
      tbl[2]  = mk(0, 1, 0, 0, 1, P + 4,     0, 0);
      tbl[3]  = mk(0, 1, 0, 0, 1, P + 8,     1, P);
      tbl[4]  = mk(0, 1, 0, 0, 1, P + 12,    1, P + 4);
      tbl[5]  = mk(0, 0, 0, 0, 0, P + 16,    1, P + 8);
      tbl[6]  = mk(0, 0, 0, 0, 0, P + 16,    1, P + 8);
      tbl[7]  = mk(0, 0, 0, 0, 0, P + 16,    1, P + 8);
      tbl[8]  = mk(0, 0, 0, 0, 0, P + 16,    1, P + 8);
      tbl[9]  = mk(0, 0, 0, 0, 0, P + 16,    1, P + 8);
      tbl[10] = mk(0, 1, 0, 0, 1, P + 16,    1, P + 8);
      tbl[11] = mk(0, 1, 0, 0, 1, P + 20,    1, P + 12);
      tbl[12] = mk(0, 1, 1, P + 32'h100, 0, P + 24, 1, P + 16);
      tbl[13] = mk(0, 1, 0, 0, 1, P + 32'h100, 0, 0);
      tbl[14] = mk(0, 1, 0, 0, 1, P + 32'h104, 0, 0);
      tbl[15] = mk(0, 1, 0, 0, 1, P + 32'h108, 1, P + 32'h100);
      tbl[16] = mk(0, 0, 0, 0, 0, P + 32'h10C, 1, P + 32'h104);
      tbl[17] = mk(0, 1, 1, P + 32'h40, 0, P + 32'h10C, 1, P + 32'h104);
      tbl[18] = mk(0, 1, 0, 0, 1, P + 32'h40, 0, 0);
      tbl[19] = mk(0, 1, 0, 0, 1, P + 32'h44, 0, 0);
      tbl[20] = mk(0, 1, 0, 0, 1, P + 32'h48, 1, P + 32'h40);
      tbl[21] = mk(1, 1, 0, 0, 0, P + 32'h4C, 1, P + 32'h44);
      tbl[22] = mk(0, 1, 0, 0, 1, P,         0, 0);
      tbl[23] = mk(0, 1, 0, 0, 1, P + 4,     0, 0);
      tbl[24] = mk(0, 1, 0, 0, 1, P + 8,     1, P);

      rst = 1'b1;
      dec_ready = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc = '0;
      repeat (2) @(posedge clk);

      for (int i = 0; i < NV; i++) begin
         step(tbl[i].rst, tbl[i].rdy, tbl[i].rv, tbl[i].rpc);
         chk($sformatf("row%0d instrfetch", i), 32'(instrfetch),
             32'(tbl[i].fetch));
         chk($sformatf("row%0d addr_imem", i), addr_imem, tbl[i].addr);
         chk($sformatf("row%0d dec_valid", i), 32'(dec_valid),
             32'(tbl[i].dv));
         chk($sformatf("row%0d dec_pc", i), dec_pc, tbl[i].dpc);
         chk($sformatf("row%0d dec_instr", i), dec_instr,
             tbl[i].dv ? (tbl[i].dpc ^ KEY) : 32'h0);
         chk($sformatf("row%0d fetch_fault", i), 32'(fetch_fault), 32'h0);
      end

      // sequential fetch across the end of IMEM
      step(0, 1, 1, P + 32'h7F8);
      saw800 = 1'b0;
      for (int c = 0; c < 12; c++) begin
         step(0, 1, 0, 0);
         if (instrfetch && addr_imem == P + 32'h800) saw800 = 1'b1;
         if (dec_valid) got.push_back(dec_pc);
      end
      chk("edge first word", got.size() > 0 ? got[0] : 32'hFFFF_FFFF,
          P + 32'h7F8);
`ifdef FETCH_RANGE_CHECK_EN
      chk("edge no fetch 800", 32'(saw800), 32'h0);
      chk("edge words", 32'(got.size()), 32'd2);
      chk("edge second word", got.size() > 1 ? got[1] : 32'hFFFF_FFFF,
          P + 32'h7FC);
      chk("edge fault", 32'(fetch_fault), 32'h1);
      chk("edge fault_pc", fault_pc, P + 32'h800);
`else
      chk("edge fetch 800", 32'(saw800), 32'h1);
      chk("edge no fault", 32'(fetch_fault), 32'h0);
`endif
      step(0, 1, 1, P);
      step(0, 1, 0, 0);
      chk("clear fault", 32'(fetch_fault), 32'h0);
      chk("clear fetch", 32'(instrfetch), 32'h1);
      chk("clear addr", addr_imem, P);

      // lost IMEM response
      step(0, 1, 1, P + 32'h200);
      step(0, 1, 0, 0);
      miss = 1'b1;
      chk("miss req addr", addr_imem, P + 32'h200);
      chk("miss req fetch", 32'(instrfetch), 32'h1);
      step(0, 1, 0, 0);
      miss = 1'b0;
      step(0, 1, 0, 0);
`ifdef FETCH_RANGE_CHECK_EN
      chk("miss fault", 32'(fetch_fault), 32'h1);
      chk("miss fault_pc", fault_pc, P + 32'h200);
      chk("miss stops fetch", 32'(instrfetch), 32'h0);
`else
      found = 1'b0;
      for (int c = 0; c < 6 && !found; c++) begin
         if (dec_valid) found = 1'b1;
         else step(0, 1, 0, 0);
      end
      chk("miss found word", 32'(found), 32'h1);
      chk("miss skips word", dec_pc, P + 32'h204);
      chk("miss no fault", 32'(fetch_fault), 32'h0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
      $finish;
   end

endmodule
